mcu0_loader: RTL and testbench

- Program loader: the writing end of the mcu0 memory's word interface (write strobe, 12-bit byte address, 16-bit word).
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. Writes them to consecutive even byte addresses starting at 0x000.
- Releases the mcu via cpu_run only after the stream's checksum verifies.
- Sits beside the memory. The mcu is held stopped while cpu_run=0.

---
 rtl/mcu0_loader.sv | 182 ++++++++++++++++++
 tb/tb_mcu0_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcu0_loader.sv
// mcu0_loader: program loader for the mcu0 memory word-write port.
// Receives a byte stream over a valid/ready handshake, laid out as
//   N_hi, N_lo, N x (word_hi, word_lo), checksum
// and writes the big-endian words to byte addresses 0, 2, 4, ...
// The trailing checksum byte must equal the XOR of every byte before it.
// cpu_run is raised only after that check succeeds.
//
// Ports:
//   clock     system clock; all state changes on its rising edge
//   reset_n   synchronous active-low reset
//   start     begin or restart a load; honoured only in IDLE, DONE and ERR
//   in_valid  in_data carries a byte this cycle
//   in_data   stream byte
//   in_ready  loader can take a byte this cycle
//   mw        memory write strobe, one-cycle pulse per word
//   mwi       memory byte address of the word being written
//   mwd       word being written, {high byte, low byte}
//   cpu_run   program loaded and verified; the mcu may run
//   done      load finished with a good checksum (level)
//   error     header count too large or checksum bad (level)
module mcu0_loader #(
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = 16,
  parameter int unsigned MAXW = 2048
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mw,
  output logic [AW-1:0] mwi,
  output logic [DW-1:0] mwd,
  output logic          cpu_run,
  output logic          done,
  output logic          error
);

  // Width of the header word count and of the running word counter.
  localparam int unsigned NW = 16;
  localparam int unsigned BW = 8;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_HDR_HI  = 4'd1;
  localparam logic [3:0] S_HDR_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CSUM    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0]    state, state_nxt;
  logic [NW-1:0] n_q, n_nxt;
  logic [NW-1:0] cnt_q, cnt_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [BW-1:0] hi_q, hi_nxt;
  logic [BW-1:0] csum_q, csum_nxt;
  logic [AW-1:0] mwi_nxt;
  logic [DW-1:0] mwd_nxt;
  logic          in_ready_nxt, mw_nxt, done_nxt, error_nxt, cpu_run_nxt;
  logic          xfer;
  logic [NW-1:0] hdr;

  // in_ready is registered from the next state, so it always matches the
  // current state and can be used directly to qualify a transfer.
  assign xfer = in_valid & in_ready;
  assign hdr  = {n_q[NW-1:BW], in_data};

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      hi_q     <= '0;
      csum_q   <= '0;
      in_ready <= 1'b0;
      mw       <= 1'b0;
      mwi      <= '0;
      mwd      <= '0;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      n_q      <= n_nxt;
      cnt_q    <= cnt_nxt;
      addr_q   <= addr_nxt;
      hi_q     <= hi_nxt;
      csum_q   <= csum_nxt;
      in_ready <= in_ready_nxt;
      mw       <= mw_nxt;
      mwi      <= mwi_nxt;
      mwd      <= mwd_nxt;
      cpu_run  <= cpu_run_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    cnt_nxt   = cnt_q;
    addr_nxt  = addr_q;
    hi_nxt    = hi_q;
    csum_nxt  = csum_q;
    mwi_nxt   = mwi;
    mwd_nxt   = mwd;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt = S_HDR_HI;
          cnt_nxt   = '0;
          addr_nxt  = '0;
          csum_nxt  = '0;
        end
      end
      S_HDR_HI: begin
        if (xfer) begin
          n_nxt     = {in_data, n_q[BW-1:0]};
          csum_nxt  = csum_q ^ in_data;
          state_nxt = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          n_nxt    = hdr;
          csum_nxt = csum_q ^ in_data;
          if (hdr > NW'(MAXW))   state_nxt = S_ERR;
          else if (hdr == '0)    state_nxt = S_CSUM;
          else                   state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_nxt    = in_data;
          csum_nxt  = csum_q ^ in_data;
          state_nxt = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        // Word and address are captured here so they are on the port
        // during the WRITE cycle and then hold until the next word.
        if (xfer) begin
          csum_nxt  = csum_q ^ in_data;
          mwi_nxt   = addr_q;
          mwd_nxt   = DW'({hi_q, in_data});
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // After the last word (N = MAXW) the address wraps to 0; unused.
        addr_nxt = addr_q + AW'(2);
        cnt_nxt  = cnt_q + NW'(1);
        if (cnt_q + NW'(1) == n_q) state_nxt = S_CSUM;
        else                       state_nxt = S_DATA_HI;
      end
      S_CSUM: begin
        if (xfer) begin
          if (in_data == csum_q) state_nxt = S_DONE;
          else                   state_nxt = S_ERR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    in_ready_nxt = (state_nxt == S_HDR_HI) || (state_nxt == S_HDR_LO) ||
                   (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO) ||
                   (state_nxt == S_CSUM);
    mw_nxt       = (state_nxt == S_WRITE);
    done_nxt     = (state_nxt == S_DONE);
    cpu_run_nxt  = (state_nxt == S_DONE);
    error_nxt    = (state_nxt == S_ERR);
  end

endmodule

// File: tb/tb_mcu0_loader.sv
// Directed bench for mcu0_loader: table of complete streams with expected
// writes and flags, plus hand-written reset, trailing-byte and full-size loads.
module tb_mcu0_loader;

  logic        clock = 1'b0;
  logic        reset_n, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mw, cpu_run, done, error;
  logic [11:0] mwi;
  logic [15:0] mwd;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  stream[$];
  logic [11:0] wa[$];
  logic [15:0] wd[$];

  typedef struct {
    string       name;
    int          nbytes;
    logic [7:0]  b [8];
    bit          gaps;
    int          exp_nw;
    logic [15:0] exp_w [2];
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs [5];

  mcu0_loader dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mw       (mw),
    .mwi      (mwi),
    .mwd      (mwd),
    .cpu_run  (cpu_run),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture every write pulse; no byte may be accepted during a write.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && mw === 1'b1) begin
      wa.push_back(mwi);
      wd.push_back(mwd);
      chk("ready_low_in_write", 32'(in_ready), 32'd0);
    end
  end

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_stream(input bit gaps, input int budget);
    int  i = 0;
    int  cyc = 0;
    bit  x;
    while (i < stream.size() && cyc < budget) begin
      @(negedge clock);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = stream[i];
      end
      x = in_valid && in_ready;
      @(posedge clock);
      if (x) i++;
      cyc++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    chk("stream_consumed", 32'(i), 32'(stream.size()));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_flags(input string tag, input bit d, input bit e);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(d));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mw"}, 32'(mw), 32'd0);
    chk({tag, "_mwi"}, 32'(mwi), 32'd0);
    chk({tag, "_mwd"}, 32'(mwd), 32'd0);
    chk_flags(tag, 1'b0, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    stream.delete();
    for (int k = 0; k < v.nbytes; k++) stream.push_back(v.b[k]);
    wa.delete();
    wd.delete();
    pulse_start();
    run_stream(v.gaps, 200);
    wait_cycles(3);
    chk({v.name, "_nwrites"}, 32'(wa.size()), 32'(v.exp_nw));
    for (int k = 0; k < v.exp_nw && k < wa.size(); k++) begin
      chk({v.name, "_addr"}, 32'(wa[k]), 32'(2 * k));
      chk({v.name, "_data"}, 32'(wd[k]), 32'(v.exp_w[k]));
    end
    chk_flags(v.name, v.exp_done, v.exp_err);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [15:0] w;
    int          bad;
    int          cyc;

    vecs[0] = '{name: "basic", nbytes: 7,
                b: '{8'h00, 8'h02, 8'h00, 8'h10, 8'h20, 8'h04, 8'h36, 8'h00},
                gaps: 1'b0, exp_nw: 2, exp_w: '{16'h0010, 16'h2004},
                exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{name: "bad_csum", nbytes: 7,
                b: '{8'h00, 8'h02, 8'h00, 8'h10, 8'h20, 8'h04, 8'h37, 8'h00},
                gaps: 1'b0, exp_nw: 2, exp_w: '{16'h0010, 16'h2004},
                exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{name: "empty", nbytes: 3,
                b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                gaps: 1'b0, exp_nw: 0, exp_w: '{16'h0000, 16'h0000},
                exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{name: "gaps", nbytes: 7,
                b: '{8'h00, 8'h02, 8'h00, 8'h10, 8'h20, 8'h04, 8'h36, 8'h00},
                gaps: 1'b1, exp_nw: 2, exp_w: '{16'h0010, 16'h2004},
                exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{name: "oversize", nbytes: 2,
                b: '{8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                gaps: 1'b0, exp_nw: 0, exp_w: '{16'h0000, 16'h0000},
                exp_done: 1'b0, exp_err: 1'b1};

    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    wait_cycles(3);
    chk_reset_outputs("por");
    reset_n = 1'b1;
    wait_cycles(2);
    chk("idle_ready", 32'(in_ready), 32'd0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Bytes after an oversize header are left untouched in ERR.
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("err_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("err_no_write", 32'(wa.size()), 32'd0);
    chk_flags("err_hold", 1'b0, 1'b1);

    // Reset right after the first word is written.
    stream = '{8'h00, 8'h02, 8'h00, 8'h10};
    wa.delete();
    wd.delete();
    pulse_start();
    run_stream(1'b0, 50);
    cyc = 0;
    while (wa.size() == 0 && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    chk("mid_first_write", 32'(wa.size()), 32'd1);
    chk("mid_mwd_before_reset", 32'(mwd), 32'h0010);
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset_outputs("mid_reset");
    reset_n = 1'b1;
    wait_cycles(2);
    chk("mid_idle_ready", 32'(in_ready), 32'd0);
    run_vec(vecs[0]);

    // Full-size load: word k = k, written at byte address 2k.
    stream = '{8'h08, 8'h00};
    cs = 8'h08;
    for (int k = 0; k < 2048; k++) begin
      w = 16'(k);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    stream.push_back(cs);
    wa.delete();
    wd.delete();
    pulse_start();
    run_stream(1'b0, 10000);
    wait_cycles(3);
    chk("max_nwrites", 32'(wa.size()), 32'd2048);
    bad = 0;
    for (int k = 0; k < wa.size(); k++)
      if (wa[k] !== 12'(2 * k) || wd[k] !== 16'(k)) bad++;
    chk("max_all_words", 32'(bad), 32'd0);
    if (wa.size() > 0) begin
      chk("max_last_addr", 32'(wa[wa.size() - 1]), 32'h0FFE);
      chk("max_last_data", 32'(wd[wd.size() - 1]), 32'h07FF);
    end
    chk_flags("max", 1'b1, 1'b0);

    // Restart from DONE drops done/cpu_run on the following cycle.
    pulse_start();
    chk_flags("restart", 1'b0, 1'b0);
    chk("restart_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
